// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 write arbiter.
// Contents: FSM state enum, AXI encodings (INCR burst, 4-byte size, OKAY),
//           the 4 KB page size and a helper that flags bursts crossing a page.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [2:0]  SIZE_4B     = 3'b010;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  // Byte offset of the first byte past the burst, relative to its 4 KB page.
  // 14 bits covers the worst case 4095 + 256*4.
  function automatic logic crosses_4k(input logic [11:0] offs, input logic [7:0] len);
    logic [13:0] end_b;
    end_b = {2'b00, offs} + {4'd0, len, 2'b00} + 14'd4;
    return end_b > 14'(BOUNDARY_4K);
  endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// Two-way round-robin grant selector with a last-grant register.
// Latency: grant is combinational from req_i; last-grant updates on the clock when update_i and a request is present.
// Backpressure: none internally; the caller decides when a grant is consumed via update_i.
// Ports: clk_i/rst_ni clock and async active-low reset, req_i request vector,
//        update_i commit the current grant, gnt_vld_o any request, gnt_idx_o winner.
module fb_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_q;   // tie goes to whoever did not win last
      default: gnt_idx_o = 1'b0;
    endcase
    last_d = (update_i && gnt_vld_o) ? gnt_idx_o : last_q;
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates two burst-write requesters onto one AXI4 write master, one burst outstanding at a time.
// Latency: grant/reject in the IDLE cycle, AW the next cycle, W beats pass straight through, done on BVALID.
// Backpressure: AWREADY stalls ADDR, WREADY/wd_valid stall beats combinationally, BVALID gates completion.
// Ports: rq_* request/accept/complete per requester, wd_* write beat handshake per requester,
//        M_AXI_AW*/W*/B* single AXI4 write channel set (INCR, 4-byte beats, AWID = requester index).
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 15
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            rq_valid,
  output logic [1:0]            rq_ready,
  input  logic [2*ADDR_W-1:0]   rq_addr,
  input  logic [15:0]           rq_len,
  input  logic [2*DATA_W-1:0]   wd_data,
  input  logic [1:0]            wd_valid,
  output logic [1:0]            wd_ready,
  output logic [1:0]            rq_done,
  output logic [1:0]            rq_err,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWID,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BID,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
  logic [7:0]          len_q, len_d, sel_len;
  logic [7:0]          cnt_q, cnt_d;
  logic                id_q, id_d;
  logic                gnt_vld, gnt_idx, illegal;
  logic                unused_bid;

  // Single outstanding burst means BID carries no information.
  assign unused_bid = M_AXI_BID;

  fb_rr_arbiter u_rr (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .req_i     (rq_valid),
    .update_i  (state_q == ST_IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_addr = gnt_idx ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
  assign sel_len  = gnt_idx ? rq_len[15:8] : rq_len[7:0];
  assign illegal  = (sel_addr[1:0] != 2'b00) || (sel_len > 8'(MAX_LEN)) ||
                    crosses_4k(sel_addr[11:0], sel_len);

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = SIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWID    = id_q;
  assign M_AXI_WSTRB   = 4'hF;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    rq_ready      = 2'b00;
    rq_done       = 2'b00;
    rq_err        = 2'b00;
    wd_ready      = 2'b00;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    // The IDLE grant path is combinational from rq_valid, so it must be
    // gated explicitly to keep every handshake output low while in reset.
    if (ARESETN) begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            rq_ready[gnt_idx] = 1'b1;
            if (illegal) begin
              rq_err[gnt_idx] = 1'b1;
            end else begin
              addr_d  = sel_addr;
              len_d   = sel_len;
              id_d    = gnt_idx;
              cnt_d   = 8'd0;
              state_d = ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          M_AXI_AWVALID = 1'b1;
          if (M_AXI_AWREADY) state_d = ST_DATA;
        end
        ST_DATA: begin
          M_AXI_WVALID     = wd_valid[id_q];
          M_AXI_WDATA      = id_q ? wd_data[2*DATA_W-1:DATA_W] : wd_data[DATA_W-1:0];
          M_AXI_WLAST      = (cnt_q == len_q);
          wd_ready[id_q]   = M_AXI_WREADY;
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            cnt_d = cnt_q + 8'd1;
            if (M_AXI_WLAST) state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          M_AXI_BREADY = 1'b1;
          if (M_AXI_BVALID) begin
            rq_done[id_q] = 1'b1;
            rq_err[id_q]  = (M_AXI_BRESP != RESP_OKAY);
            state_d       = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  logic        ACLK;
  logic        ARESETN;
  logic [1:0]  rq_valid, rq_ready, wd_valid, wd_ready, rq_done, rq_err;
  logic [63:0] rq_addr, wd_data;
  logic [15:0] rq_len;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST, M_AXI_BRESP;
  logic        M_AXI_AWID, M_AXI_AWVALID, M_AXI_AWREADY;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BID, M_AXI_BVALID, M_AXI_BREADY;
  logic [11:0] outs_all;

  int total = 0;
  int bad   = 0;

  fb_write_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LEN(15)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr), .rq_len(rq_len),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rq_done(rq_done), .rq_err(rq_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BID(M_AXI_BID), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  assign outs_all = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_WLAST,
                     rq_ready, rq_done, rq_err, wd_ready};

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  bresp;
    int          aw_wait;
    bit          gaps;
    bit          rej;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int id, input int b);
    return 32'h11 * 32'(b + 1) + (32'(id) << 28);
  endfunction

  task automatic clear_inputs();
    rq_valid      = 2'b00;
    wd_valid      = 2'b00;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
  endtask

  // One request from a single requester, with a slave model driving AW/W/B.
  task automatic burst(input string tag, input int id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] bresp, input int aw_wait, input bit gaps, input bit exp_rej);
    bit acc = 0, acc_err = 0, aw_done = 0, w_done = 0, fin = 0, done_err = 0, bready = 0;
    int aw_seen = 0, aw_unstable = 0, wv_early = 0, beats = 0;
    int wlast_bad = 0, data_bad = 0, pass_bad = 0;
    logic [31:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic        aw_id = 1'b0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge ACLK); #1;
      rq_valid = 2'b00;
      rq_valid[id] = !acc;
      rq_addr[id*32 +: 32] = addr;
      rq_len[id*8 +: 8] = len;
      M_AXI_AWREADY = (aw_seen >= aw_wait);
      wd_valid = 2'b00;
      wd_valid[id] = acc && !w_done && (!gaps || (c % 3) != 1);
      wd_data[id*32 +: 32] = dat(id, beats);
      M_AXI_WREADY = !gaps || ((c % 2) == 0);
      M_AXI_BVALID = w_done;
      M_AXI_BRESP  = bresp;
      #1;
      if (!acc && rq_ready[id]) begin
        acc = 1; acc_err = rq_err[id];
        if (exp_rej) fin = 1;
      end
      if (!aw_done && M_AXI_WVALID) wv_early++;
      if (aw_done && !w_done) begin
        if (wd_ready[id] !== M_AXI_WREADY || wd_ready[1-id] !== 1'b0 ||
            M_AXI_WVALID !== wd_valid[id]) pass_bad++;
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          if (M_AXI_WDATA !== dat(id, beats) || M_AXI_WSTRB !== 4'hF) data_bad++;
          if (M_AXI_WLAST !== (beats == int'(len))) wlast_bad++;
          beats++;
          if (beats == int'(len) + 1) w_done = 1;
        end
      end
      if (M_AXI_AWVALID) begin
        if (aw_seen == 0) begin
          aw_addr = M_AXI_AWADDR; aw_len = M_AXI_AWLEN; aw_id = M_AXI_AWID;
          aw_size = M_AXI_AWSIZE; aw_burst = M_AXI_AWBURST;
        end else if (M_AXI_AWADDR !== aw_addr || M_AXI_AWLEN !== aw_len || M_AXI_AWID !== aw_id)
          aw_unstable++;
        aw_seen++;
        if (M_AXI_AWREADY) aw_done = 1;
      end
      if (M_AXI_BVALID && rq_done[id]) begin
        fin = 1; done_err = rq_err[id]; bready = M_AXI_BREADY;
      end
    end
    check({tag, " accepted"}, acc, 1);
    check({tag, " err at accept"}, acc_err, exp_rej);
    if (exp_rej) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge ACLK); #1; rq_valid = 2'b00; #1;
        if (M_AXI_AWVALID) aw_seen++;
      end
      check({tag, " no AW on reject"}, aw_seen, 0);
    end else begin
      check({tag, " finished"}, fin, 1);
      check({tag, " awaddr"}, aw_addr, addr);
      check({tag, " awlen"}, aw_len, len);
      check({tag, " awid"}, aw_id, id[0]);
      check({tag, " awsize"}, aw_size, 3'b010);
      check({tag, " awburst"}, aw_burst, 2'b01);
      check({tag, " aw stable"}, aw_unstable, 0);
      check({tag, " aw cycles"}, aw_seen, aw_wait + 1);
      check({tag, " wvalid early"}, wv_early, 0);
      check({tag, " beats"}, beats, int'(len) + 1);
      check({tag, " wlast"}, wlast_bad, 0);
      check({tag, " wdata"}, data_bad, 0);
      check({tag, " passthru"}, pass_bad, 0);
      check({tag, " done err"}, done_err, (bresp != 2'b00));
      check({tag, " bready"}, bready, 1);
    end
    @(posedge ACLK); #1;
    clear_inputs();
  endtask

  initial begin
    int cnt0, cnt1, n, beats, awv;
    bit acc;
    int order [6];
    int gcyc  [6];

    vecs[0] = '{0, 32'h0000_0100, 8'd3,  2'b00, 0, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h0000_0FF8, 8'd3,  2'b00, 0, 1'b0, 1'b1};
    vecs[2] = '{0, 32'h0000_0200, 8'd7,  2'b00, 5, 1'b1, 1'b0};
    vecs[3] = '{1, 32'h0000_0300, 8'd1,  2'b10, 0, 1'b0, 1'b0};
    vecs[4] = '{0, 32'h0000_0400, 8'd0,  2'b00, 0, 1'b0, 1'b0};
    vecs[5] = '{0, 32'h0000_0102, 8'd0,  2'b00, 0, 1'b0, 1'b1};
    vecs[6] = '{1, 32'h0000_0000, 8'd16, 2'b00, 0, 1'b0, 1'b1};
    vecs[7] = '{1, 32'h0000_0FC0, 8'd15, 2'b00, 2, 1'b0, 1'b0};
    vecs[8] = '{0, 32'h0000_1000, 8'd0,  2'b11, 0, 1'b1, 1'b0};

    // Reset with every input trying to provoke a handshake.
    ARESETN       = 1'b0;
    rq_valid      = 2'b11;
    rq_addr       = {32'h0000_0900, 32'h0000_0800};
    rq_len        = 16'h0000;
    wd_valid      = 2'b11;
    wd_data       = '0;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    M_AXI_BVALID  = 1'b1;
    M_AXI_BRESP   = 2'b00;
    M_AXI_BID     = 1'b0;
    #12;
    check("reset outputs", outs_all, 0);
    @(negedge ACLK);
    ARESETN  = 1'b1;
    rq_valid = 2'b00;

    // Round robin: both requesters keep asking, three bursts each.
    cnt0 = 0; cnt1 = 0; n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(posedge ACLK); #1;
      rq_valid = {cnt1 < 3, cnt0 < 3};
      #1;
      if (rq_ready != 2'b00) begin
        order[n] = rq_ready[1] ? 1 : 0;
        gcyc[n]  = c;
        if (rq_ready[0]) cnt0++; else cnt1++;
        n++;
      end
    end
    check("rr grant count", n, 6);
    for (int i = 0; i < 6; i++) check($sformatf("rr order %0d", i), order[i], i % 2);
    check("rr back-to-back gap", gcyc[1] - gcyc[0], 4);
    @(posedge ACLK); #1;
    rq_valid = 2'b00;
    repeat (6) @(posedge ACLK);
    #1;
    clear_inputs();

    for (int i = 0; i < 9; i++)
      burst($sformatf("v%0d", i), vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].bresp,
            vecs[i].aw_wait, vecs[i].gaps, vecs[i].rej);

    // Reset during the second beat of a len-7 burst.
    rq_addr[31:0] = 32'h0000_0500;
    rq_len[7:0]   = 8'd7;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    wd_valid      = 2'b01;
    acc = 0; beats = 0;
    for (int c = 0; c < 50 && beats < 1; c++) begin
      @(posedge ACLK); #1;
      rq_valid[0] = !acc;
      wd_data[31:0] = dat(0, beats);
      #1;
      if (rq_ready[0]) acc = 1;
      if (M_AXI_WVALID && M_AXI_WREADY) beats++;
    end
    check("rst_mid first beat", beats, 1);
    @(posedge ACLK); #1;
    wd_data[31:0] = dat(0, 1);
    #1;
    check("rst_mid in beat2", M_AXI_WVALID, 1);
    ARESETN      = 1'b0;
    rq_valid     = 2'b01;
    M_AXI_BVALID = 1'b1;
    #1;
    check("rst_mid outputs now", outs_all, 0);
    @(posedge ACLK); #2;
    check("rst_mid outputs held", outs_all, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    clear_inputs();
    awv = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge ACLK); #2;
      if (M_AXI_AWVALID || M_AXI_WVALID) awv++;
    end
    check("rst_mid not resumed", awv, 0);
    burst("post_rst", 0, 32'h0000_0600, 8'd2, 2'b00, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
